// File: rtl/data_mem_pkg.sv
// Shared types and default geometry for the CPU data memory.
package data_mem_pkg;

    // Sequencer states: sweeping the array with the clear value, or serving LDR/STR.
    typedef enum logic {
        CLEARING = 1'b0,
        READY    = 1'b1
    } mem_state_t;

    // Default datapath geometry: 8-bit words, 256 entries.
    localparam int DM_W = 8;
    localparam int DM_A = 8;

endpackage

// File: rtl/data_mem_init_if.sv
// Load/store bus between the datapath (master) and the data memory (slave).
interface data_mem_init_if
    import data_mem_pkg::*;
#(
    parameter int W = DM_W,
    parameter int A = DM_A
);
    logic [W-1:0] data_to_write;
    logic [A-1:0] addr;
    logic         read_enabled;
    logic         write_enabled;
    logic         clear_req;
    logic [W-1:0] data_out;
    logic         read_valid;
    logic         busy;

    modport master (
        output data_to_write, addr, read_enabled, write_enabled, clear_req,
        input  data_out, read_valid, busy
    );

    modport slave (
        input  data_to_write, addr, read_enabled, write_enabled, clear_req,
        output data_out, read_valid, busy
    );
endinterface

// File: rtl/data_mem_init.sv
// Single-port data memory with registered read and a clear sequencer that
// writes CLR_VAL to every entry after reset or on a software clear request.
module data_mem_init
    import data_mem_pkg::*;
#(
    parameter int           W       = DM_W,
    parameter int           A       = DM_A,
    parameter logic [W-1:0] CLR_VAL = '0
)
(
    input  logic              clk,
    input  logic              reset,
    data_mem_init_if.slave    bus
);

    localparam int           DEPTH     = 2**A;
    // Terminal address of the sweep; compared on A bits so the pointer only
    // returns to zero together with the move to READY.
    localparam logic [A-1:0] LAST_ADDR = {A{1'b1}};

    mem_state_t   state_reg, state_next;
    logic [A-1:0] clr_ptr_reg, clr_ptr_next;
    logic         busy_reg;
    logic [W-1:0] data_out_reg;
    logic         read_valid_reg;

    // Storage is intentionally not reset; the sequencer initialises it.
    logic [W-1:0] core [DEPTH];

    // Single write port, shared between the sweep and the store path.
    logic         mem_we;
    logic [A-1:0] mem_waddr;
    logic [W-1:0] mem_wdata;
    logic         rd_accept;

    // Next-state logic, clear pointer advance and write-port mux.
    always_comb begin
        state_next   = state_reg;
        clr_ptr_next = clr_ptr_reg;
        mem_we       = 1'b0;
        mem_waddr    = bus.addr;
        mem_wdata    = bus.data_to_write;
        rd_accept    = 1'b0;
        case (state_reg)
            CLEARING: begin
                // Requests and further clear pulses are ignored mid-sweep.
                mem_we       = 1'b1;
                mem_waddr    = clr_ptr_reg;
                mem_wdata    = CLR_VAL;
                clr_ptr_next = clr_ptr_reg + A'(1);
                if (clr_ptr_reg == LAST_ADDR) begin
                    state_next   = READY;
                    clr_ptr_next = '0;
                end
            end
            READY: begin
                if (bus.clear_req) begin
                    // A clear pulse wins over any load/store in the same cycle.
                    state_next   = CLEARING;
                    clr_ptr_next = '0;
                end else begin
                    mem_we    = bus.write_enabled;
                    rd_accept = bus.read_enabled;
                end
            end
        endcase
    end

    // Sequencer state, clear pointer and registered busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= CLEARING;
            clr_ptr_reg <= '0;
            busy_reg    <= 1'b1;
        end else begin
            state_reg   <= state_next;
            clr_ptr_reg <= clr_ptr_next;
            busy_reg    <= (state_next == CLEARING);
        end
    end

    // Registered read port; the array is sampled before this edge's write lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_reg   <= '0;
            read_valid_reg <= 1'b0;
        end else if (rd_accept) begin
            data_out_reg   <= core[bus.addr];
            read_valid_reg <= 1'b1;
        end else begin
            read_valid_reg <= 1'b0;
        end
    end

    // Array write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            core[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.data_out   = data_out_reg;
    assign bus.read_valid = read_valid_reg;
    assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_data_mem_init.sv
// Bench for data_mem_init: default 8x256 instance against a behavioural model,
// plus a 16x16 instance with a non-zero clear value.
module tb_data_mem_init;
    import data_mem_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset_s = 1'b1;
    always #5 clk = ~clk;

    data_mem_init_if #(.W(8),  .A(8)) bus ();
    data_mem_init_if #(.W(16), .A(4)) bus_s ();

    data_mem_init #(.W(8), .A(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    data_mem_init #(.W(16), .A(4), .CLR_VAL(16'hDEAD)) dut_s (
        .clk   (clk),
        .reset (reset_s),
        .bus   (bus_s.slave)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: memory contents as the software sees them. A clear
    // makes the whole array CLR_VAL at once; the memory is then unavailable
    // for 256 edges, so the order of the hardware sweep is unobservable.
    logic [7:0] m_mem [256];
    int         m_left;
    logic [7:0] m_data;
    bit         m_valid;

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        m_left  = 256;
        m_data  = 8'h00;
        m_valid = 1'b0;
    endtask

    task automatic model_edge(input bit rd, input bit wr, input bit clr,
                              input logic [7:0] a, input logic [7:0] d);
        if (m_left > 0) begin
            m_left--;
            m_valid = 1'b0;
        end else if (clr) begin
            for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
            m_left  = 256;
            m_valid = 1'b0;
        end else begin
            if (rd) begin
                m_data  = m_mem[a];
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (wr) m_mem[a] = d;
        end
    endtask

    // One clock of traffic on the default instance, checked against the model.
    task automatic step(input bit rd, input bit wr, input bit clr,
                        input logic [7:0] a, input logic [7:0] d, input string tag);
        bus.read_enabled  = rd;
        bus.write_enabled = wr;
        bus.clear_req     = clr;
        bus.addr          = a;
        bus.data_to_write = d;
        @(posedge clk);
        model_edge(rd, wr, clr, a, d);
        #1;
        check({tag, " busy"},       32'(bus.busy),       32'(m_left > 0));
        check({tag, " read_valid"}, 32'(bus.read_valid), 32'(m_valid));
        check({tag, " data_out"},   32'(bus.data_out),   32'(m_data));
        bus.read_enabled  = 1'b0;
        bus.write_enabled = 1'b0;
        bus.clear_req     = 1'b0;
    endtask

    // Step until busy drops; returns the edge index of the drop (0 if never).
    task automatic run_sweep(input bit noisy, input int pulse_at, input string tag,
                             output int drop);
        drop = 0;
        for (int e = 1; e <= 400 && drop == 0; e++) begin
            if (noisy)
                step(1'($urandom), 1'($urandom), (e == pulse_at),
                     8'($urandom), 8'($urandom), tag);
            else
                step(1'b0, 1'b0, (e == pulse_at), 8'h00, 8'h00, tag);
            if (!bus.busy) drop = e;
        end
    endtask

    typedef struct {
        bit         rd;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] din;
        bit         exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int drop;
        bus.read_enabled = 0; bus.write_enabled = 0; bus.clear_req = 0;
        bus.addr = 0; bus.data_to_write = 0;
        bus_s.read_enabled = 0; bus_s.write_enabled = 0; bus_s.clear_req = 0;
        bus_s.addr = 0; bus_s.data_to_write = 0;

        vecs[0] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 8'h7F, 8'h00, 1'b1, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 8'h00};
        vecs[3] = '{1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, 8'h00};
        vecs[4] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 8'hA5};
        vecs[5] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 8'hA5};
        vecs[6] = '{1'b1, 1'b0, 8'h11, 8'h00, 1'b1, 8'h00};
        vecs[7] = '{1'b1, 1'b1, 8'h10, 8'h3C, 1'b1, 8'hA5};
        vecs[8] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 8'h3C};
        vecs[9] = '{1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 8'h3C};

        // Reset state of both instances.
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",         32'(bus.busy),         32'd1);
        check("reset read_valid",   32'(bus.read_valid),   32'd0);
        check("reset data_out",     32'(bus.data_out),     32'd0);
        check("reset_s busy",       32'(bus_s.busy),       32'd1);
        check("reset_s data_out",   32'(bus_s.data_out),   32'd0);

        // Post-reset sweep length.
        reset = 1'b0;
        run_sweep(1'b0, 0, "init sweep", drop);
        check("init sweep length", 32'(drop), 32'd256);

        // Table: initial reads, write then read, back-to-back, read-before-write.
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].rd, vecs[i].wr, 1'b0, vecs[i].addr, vecs[i].din, "vec");
            check($sformatf("vec%0d read_valid", i), 32'(bus.read_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d data_out", i),   32'(bus.data_out),   32'(vecs[i].exp_data));
        end

        // Fill with address values, then clear together with a write to 0x20.
        for (int i = 0; i < 256; i++) step(1'b0, 1'b1, 1'b0, 8'(i), 8'(i), "fill");
        step(1'b1, 1'b0, 1'b0, 8'h42, 8'h00, "fill readback");
        check("fill readback 0x42", 32'(bus.data_out), 32'h42);
        step(1'b1, 1'b1, 1'b1, 8'h20, 8'h55, "clear+write");
        check("clear+write read_valid", 32'(bus.read_valid), 32'd0);
        run_sweep(1'b1, 50, "noisy sweep", drop);
        check("clear sweep length", 32'(drop), 32'd256);
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'(i), 8'h00, "post-clear");
            check($sformatf("post-clear @%0h", i), 32'(bus.data_out), 32'h00);
        end

        // Reset midway through a sweep.
        step(1'b0, 1'b1, 1'b0, 8'h05, 8'h99, "pre-reset write");
        step(1'b1, 1'b0, 1'b0, 8'h05, 8'h00, "pre-reset read");
        check("pre-reset data", 32'(bus.data_out), 32'h99);
        step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, "start clear");
        for (int i = 0; i < 128; i++) step(1'b1, 1'b0, 1'b0, 8'h05, 8'h00, "half sweep");
        check("hold data during sweep", 32'(bus.data_out), 32'h99);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check("async reset data_out",   32'(bus.data_out),   32'd0);
        check("async reset read_valid", 32'(bus.read_valid), 32'd0);
        check("async reset busy",       32'(bus.busy),       32'd1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        run_sweep(1'b0, 100, "restart sweep", drop);
        check("restart sweep length", 32'(drop), 32'd256);

        // Randomised traffic with occasional clear pulses.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom), 1'($urandom), ($urandom_range(0, 99) == 0),
                 8'($urandom_range(0, 15)), 8'($urandom), "random");
        end

        // Narrow instance with a non-zero clear value.
        @(posedge clk);
        #1;
        reset_s = 1'b0;
        drop = 0;
        for (int e = 1; e <= 40 && drop == 0; e++) begin
            @(posedge clk);
            #1;
            if (!bus_s.busy) drop = e;
        end
        check("small sweep length", 32'(drop), 32'd16);
        for (int i = 0; i < 16; i++) begin
            bus_s.read_enabled = 1'b1;
            bus_s.addr = 4'(i);
            @(posedge clk);
            #1;
            check($sformatf("small clear @%0h", i), 32'(bus_s.data_out), 32'hDEAD);
            check($sformatf("small valid @%0h", i), 32'(bus_s.read_valid), 32'd1);
        end
        bus_s.read_enabled = 1'b0;
        bus_s.write_enabled = 1'b1;
        bus_s.addr = 4'hF;
        bus_s.data_to_write = 16'hBEEF;
        @(posedge clk);
        #1;
        check("small write read_valid", 32'(bus_s.read_valid), 32'd0);
        bus_s.write_enabled = 1'b0;
        bus_s.read_enabled = 1'b1;
        @(posedge clk);
        #1;
        check("small readback 0xF", 32'(bus_s.data_out), 32'hBEEF);
        bus_s.addr = 4'hE;
        @(posedge clk);
        #1;
        check("small readback 0xE", 32'(bus_s.data_out), 32'hDEAD);
        bus_s.read_enabled = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/data_mem_init.md
# data_mem_init

Parametrised single-port data memory with a built-in clear sequencer and registered read. It replaces the bare combinational-read data memory in the CPU datapath: it serves LDR/STR traffic with a fixed 1-cycle read latency. It also guarantees a known memory image after reset, or after a software-requested clear, by walking every address and writing `CLR_VAL`.

## Interface

Parameters:
- `W`, default 8: data width in bits.
- `A`, default 8: address width; depth is 2**A entries.
- `CLR_VAL`, default `'0`: W-bit value written to every entry during a clear.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-high; reset is asynchronous and active-high.
- `data_to_write`, in, W: store data.
- `addr`, in, A: shared read/write address.
- `read_enabled`, in, 1: load request, sampled on the clk edge.
- `write_enabled`, in, 1: store request, sampled on the clk edge.
- `clear_req`, in, 1: single-cycle pulse that starts a full memory clear.
- `data_out`, out, W: registered read data.
- `read_valid`, out, 1: one-cycle pulse; `data_out` holds new load data.
- `busy`, out, 1: high while clearing; requests are ignored while high.

## Operation

- Two states: `CLEARING` and `READY`.
- Asynchronous `reset` forces:
  - `state=CLEARING`, `clr_ptr=0`
  - `busy=1`, `read_valid=0`, `data_out=0`
- The storage array itself is not reset; only the sequencer clears it.
- In `CLEARING`, each edge:
  - Writes `CLR_VAL` to `core[clr_ptr]` and increments `clr_ptr`.
  - On the edge that writes address 2**A-1, moves to `READY` and drops `busy`.
  - `clr_ptr` is A+1 bits wide, or the terminal compare is done on A bits; it must never wrap silently.
- In `READY`:
  - `write_enabled`: `core[addr] <= data_to_write`.
  - `read_enabled`: `data_out <= core[addr]` and `read_valid <= 1`; otherwise `read_valid <= 0` and `data_out` holds.
- Read and write to the same address in the same cycle: read-before-write. `data_out` returns the old contents, and the array holds the new value afterwards.
- `clear_req` sampled high in `READY`:
  - Enters `CLEARING` with `clr_ptr=0` on that edge.
  - Any read or write in the same cycle is dropped, and `read_valid` stays 0.
- `clear_req` while already `CLEARING` is ignored; the sweep does not restart.
- `read_enabled`/`write_enabled` during `CLEARING` are ignored, with no side effects. `read_valid=0` and `data_out` holds its last value.
- `reset` asserted mid-clear aborts the sweep. After release, a full 2**A-cycle sweep restarts from address 0.

## Timing

- Clear duration: `busy` is high for exactly 2**A rising edges after `reset` deasserts, or after the edge that sampled `clear_req`.
- The first accepted request is on the edge after the final clear write.
- Read latency is 1 cycle:
  - A request sampled at edge k gives `data_out`/`read_valid` updated at edge k.
  - Both are valid throughout cycle k+1.
- Back-to-back reads every cycle are supported; `read_valid` stays high continuously.
- Write latency: a write sampled at edge k is visible to a read sampled at edge k+1.
- `busy` is a registered output, with no combinational path from inputs.
- No combinational path from `addr` to `data_out`.

## Structure

- Shared package `data_mem_pkg`:
  - typedef enum `mem_state_t {CLEARING, READY}`
  - default `W`/`A` localparams used by the datapath
- Single module; no sub-module is warranted. The clear pointer and FSM stay inline (about 150 lines of RTL).
- The array is declared `logic [W-1:0] core[2**A]`, with one write port muxed between the sequencer and the store path. This keeps it inferable as a single-port RAM.

## Test plan

All scenarios use defaults W=8, A=8.

1. Release `reset`, count cycles:
   - `busy` is high for exactly 256 edges, then 0.
   - Reads of 0x00, 0x7F and 0xFF return 0x00, with `read_valid` pulsing one cycle after each request.
2. Write 0xA5 @0x10, then read @0x10 next cycle:
   - `data_out=0xA5` and `read_valid=1` in the following cycle.
   - Back-to-back reads @0x10, 0x11 give 0xA5 then 0x00, with `read_valid` high 2 cycles.
3. With 0xA5 @0x10, issue write 0x3C plus read @0x10 in the same cycle:
   - `data_out=0xA5`.
   - The next read @0x10 returns 0x3C.
4. Fill 0x00–0xFF with the address value, pulse `clear_req` together with write 0x55 @0x20:
   - `busy` is high for 256 cycles; writes and reads issued during the sweep are ignored, `read_valid=0`.
   - Afterwards every address reads 0x00, including 0x20.
5. During a clear, assert `reset` when `clr_ptr`=0x80, release after 3 cycles:
   - `data_out=0`, `read_valid=0` immediately.
   - `busy` is high for a full 256 cycles after release.
   - A `clear_req` pulse mid-sweep does not extend `busy`.
6. Regression at W=16, A=4, `CLR_VAL`=16'hDEAD:
   - `busy` lasts 16 cycles.
   - All 16 entries read 0xDEAD.
   - Write/read of 0xBEEF @0xF round-trips.
